m_unit: RTL and testbench

M_UNIT -- requirements
Module: m_unit

---
 rtl/m_unit.sv | 202 ++++++++++++++++++++
 tb/tb_m_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/m_unit.sv
// m_unit: RV32M multiply/divide unit (shift-add multiply, restoring divide, 32 iterations).
// Optional macro M_UNIT_FAST_MUL_EN: single-cycle 33x33 signed multiplier for all multiplies.
module m_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic [1:0]  state_q,  state_d;
  logic [2:0]  op_q,     op_d;
  logic        neg_q,    neg_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [63:0] mcand_q,  mcand_d;
  logic [31:0] opb_q,    opb_d;
  logic [63:0] acc_q,    acc_d;
  logic [31:0] result_q, result_d;

  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

  // Operand decode for the accept cycle
  logic        in_is_div;
  logic        rs1_signed, rs2_signed;
  logic        rs1_neg, rs2_neg;
  logic [31:0] rs1_mag, rs2_mag;
  logic        div_by_zero, div_ovf;
  logic [31:0] div_fast_res;

  always_comb begin
    in_is_div   = funct3[2];
    rs1_signed  = (funct3 != F_MULHU) && (funct3 != F_DIVU) && (funct3 != F_REMU);
    rs2_signed  = rs1_signed && (funct3 != F_MULHSU);
    rs1_neg     = rs1_signed && rs1_data[31];
    rs2_neg     = rs2_signed && rs2_data[31];
    rs1_mag     = neg_if(rs1_neg, rs1_data);
    rs2_mag     = neg_if(rs2_neg, rs2_data);
    div_by_zero = in_is_div && (rs2_data == '0);
    div_ovf     = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                  (rs1_data == 32'h8000_0000) && (rs2_data == '1);
    if (div_by_zero)
      div_fast_res = funct3[1] ? rs1_data : '1;
    else
      div_fast_res = funct3[1] ? '0 : 32'h8000_0000;
  end

`ifdef M_UNIT_FAST_MUL_EN
  logic signed [32:0] fm_a, fm_b;
  logic signed [65:0] fm_prod;
  logic [31:0]        fm_res;
  logic               unused_fm_bits;

  always_comb begin
    fm_a    = {rs1_neg, rs1_data};
    fm_b    = {rs2_neg, rs2_data};
    fm_prod = 66'(fm_a) * 66'(fm_b);
    fm_res  = (funct3 == F_MUL) ? fm_prod[31:0] : fm_prod[63:32];
  end

  assign unused_fm_bits = ^fm_prod[65:64];
`endif

  // One iteration of either datapath, shared by the final-cycle result
  logic [63:0] acc_step;
  logic [63:0] mcand_step;
  logic [31:0] opb_step;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_signed;
  logic [31:0] calc_res;

  always_comb begin
    div_shift  = {acc_q[63:32], acc_q[31]};
    div_ge     = div_shift >= {1'b0, opb_q};
    // The true difference is below the divisor, so modular 32-bit subtraction is exact
    div_diff   = div_shift[31:0] - opb_q;
    mcand_step = mcand_q;
    opb_step   = opb_q;
    if (op_q[2]) begin
      acc_step = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};
    end else begin
      acc_step   = acc_q + (opb_q[0] ? mcand_q : '0);
      mcand_step = {mcand_q[62:0], 1'b0};
      opb_step   = {1'b0, opb_q[31:1]};
    end
    prod_signed = neg_q ? (~acc_step + 64'd1) : acc_step;
    if (op_q[2])
      calc_res = op_q[1] ? neg_if(neg_q, acc_step[63:32]) : neg_if(neg_q, acc_step[31:0]);
    else
      calc_res = (op_q == F_MUL) ? prod_signed[31:0] : prod_signed[63:32];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d  = funct3;
          neg_d = (funct3 == F_REM || funct3 == F_REMU) ? rs1_neg : (rs1_neg ^ rs2_neg);
          cnt_d = '0;
          opb_d = rs2_mag;
          if (in_is_div) begin
            acc_d   = {32'b0, rs1_mag};
            mcand_d = '0;
          end else begin
            acc_d   = '0;
            mcand_d = {32'b0, rs1_mag};
          end
          if (div_by_zero || div_ovf) begin
            state_d  = DONE;
            result_d = div_fast_res;
          end else begin
`ifdef M_UNIT_FAST_MUL_EN
            if (!in_is_div) begin
              state_d  = DONE;
              result_d = fm_res;
            end else begin
              state_d = CALC;
            end
`else
            state_d = CALC;
`endif
          end
        end
      end
      CALC: begin
        acc_d   = acc_step;
        mcand_d = mcand_step;
        opb_d   = opb_step;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = DONE;
          result_d = calc_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush drops whatever was decided above and leaves result untouched
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_m_unit.sv
// tb_m_unit: directed self-checking bench for m_unit (results, latency, flush, reset).
// Expected multiply latency follows M_UNIT_FAST_MUL_EN when the bench is built with it.
module tb_m_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

`ifdef M_UNIT_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  m_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle, scrambles inputs afterwards, waits for done.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    funct3 = f; rs1_data = a; rs2_data = b; start = 1'b1;
    tick;
    start = 1'b0; funct3 = ~f; rs1_data = ~a; rs2_data = ~b;
    check({tag, " busy"}, {31'b0, busy}, 32'd1);
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      tick;
      lat++;
    end
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " res"}, result, exp);
    tick;
    check({tag, " idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
    tick;
    tick;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst result", result, 32'd0);
    rst = 1'b0;
    start = 1'b1;
    flush = 1'b1;
    tick;
    check("post-rst flush+start", {30'b0, busy, done}, 32'd0);
    start = 1'b0;
    flush = 1'b0;

    run_op("mul 7x-3",      F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulhu max",     F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mul low",       F_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT);
    run_op("mulh min x2",   F_MULH,   32'h8000_0000, 32'd2,         32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhsu -1xmax", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulh 7x-3",     F_MULH,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT);
    run_op("div -7/2",      F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
    run_op("rem -7/2",      F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
    run_op("div 7/-2",      F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem 7/-2",      F_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT);
    run_op("divu max/1",    F_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, DIV_LAT);
    run_op("remu max/16",   F_REMU,   32'hFFFF_FFFF, 32'h10,        32'h0000_000F, DIV_LAT);
    run_op("div min/1",     F_DIV,    32'h8000_0000, 32'd1,         32'h8000_0000, DIV_LAT);
    run_op("divu 5/0",      F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem 5/0",       F_REM,    32'd5,         32'd0,         32'd5,         1);
    run_op("div ovf",       F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf",       F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("divu 100/7",    F_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT);
    run_op("remu 100/7",    F_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT);

    // Flush during CALC: start at T, flush high in T+10
    funct3 = F_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
    tick;
    start = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      if (done) seen = 1'b1;
      tick;
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush no done", {31'b0, seen | done}, 32'd0);
    check("flush result", result, 32'd2);
    run_op("after flush", F_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);

    // Flush and start together in IDLE: start dropped
    funct3 = F_DIVU; rs1_data = 32'd9; rs2_data = 32'd0; start = 1'b1; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    check("idle flush wins", {30'b0, busy, done}, 32'd0);
    tick;
    check("idle flush stays", {30'b0, busy, done}, 32'd0);
    check("idle flush result", result, 32'd14);

    // Flush while in DONE: the pulse still stands
    funct3 = F_DIVU; rs1_data = 32'd5; rs2_data = 32'd0; start = 1'b1;
    tick;
    start = 1'b0; flush = 1'b1;
    #1;
    check("done flush pulse", {31'b0, done}, 32'd1);
    check("done flush result", result, 32'hFFFF_FFFF);
    tick;
    flush = 1'b0;
    check("done flush idle", {30'b0, busy, done}, 32'd0);

    // Start re-asserted with new operands during CALC is ignored
    funct3 = F_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    repeat (2) begin tick; lat++; end
    funct3 = F_DIV; rs1_data = 32'd200; rs2_data = 32'd3; start = 1'b1;
    repeat (5) begin tick; lat++; end
    start = 1'b0;
    while (done !== 1'b1 && lat < 60) begin
      tick;
      lat++;
    end
    check("ignore lat", 32'(lat), 32'd33);
    check("ignore res", result, 32'd14);
    tick;
    check("ignore idle", {30'b0, busy, done}, 32'd0);

    // Reset mid-operation at T+5
    funct3 = F_MULHU; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'hFFFF_FFFF; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst flags", {30'b0, busy, done}, 32'd0);
    check("midrst result", result, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (busy || done) seen = 1'b1;
      tick;
    end
    check("midrst quiet", {31'b0, seen}, 32'd0);

    run_op("post rst mul", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
